// File: rtl/rs_dispatch_pkg.sv
// rtl/rs_dispatch_pkg.sv - shared types and helpers for the RS encoder line dispatcher
//
// Purpose: dispatcher FSM state encoding, the default unit index width and an
//          index-width helper used to size counters from module parameters.
// Ports:   none (package).

package rs_dispatch_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int DEF_NUM_RS_UNITS = 16;
   localparam int UNIT_W           = $clog2(DEF_NUM_RS_UNITS);

   // Index width for a counter over n values; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rs_encoder_line_dispatch.sv
// rtl/rs_encoder_line_dispatch.sv - round-robin block dispatcher feeding an array of RS encoder units
//
// Purpose: splits an in-order line stream into blocks of NUM_LINES lines and
//          hands each block to the next encoder unit in strict rotation, so a
//          downstream reducer visiting units in the same order restores the stream.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   dispatch_en                     level enable, honoured on block boundaries only
//   src_dispatch_line_val/_line/_line_last, dispatch_src_line_rdy
//                                   input line stream with handshake
//   dispatch_encoder_line_vals      one-hot valid towards the selected unit
//   dispatch_encoder_line           line data broadcast to all units
//   encoder_dispatch_line_rdys      per-unit ready
//   dispatch_framing_err            sticky: last flag disagreed with line count
//   dispatch_blocks_sent            number of fully accepted blocks (mod 2^32)
//   dispatch_idle                   FSM idle and output register empty

module rs_encoder_line_dispatch
   import rs_dispatch_pkg::*;
#(
   parameter int NUM_RS_UNITS = 16,
   parameter int DATA_W       = -1,
   parameter int NUM_LINES    = -1,
   // Clamped copies keep the unconfigured defaults elaboratable.
   localparam int DW          = (DATA_W > 0) ? DATA_W : 1,
   localparam int NL          = (NUM_LINES > 0) ? NUM_LINES : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    dispatch_en,
   input  logic                    src_dispatch_line_val,
   input  logic [DW-1:0]           src_dispatch_line,
   input  logic                    src_dispatch_line_last,
   output logic                    dispatch_src_line_rdy,
   output logic [NUM_RS_UNITS-1:0] dispatch_encoder_line_vals,
   output logic [DW-1:0]           dispatch_encoder_line,
   input  logic [NUM_RS_UNITS-1:0] encoder_dispatch_line_rdys,
   output logic                    dispatch_framing_err,
   output logic [31:0]             dispatch_blocks_sent,
   output logic                    dispatch_idle
);

   localparam int UW   = idx_w(NUM_RS_UNITS);
   localparam int LC_W = idx_w(NL);
   localparam logic [LC_W-1:0] LAST_LINE = LC_W'(NL - 1);

   typedef struct packed {
      logic [DW-1:0] data;
      logic [UW-1:0] unit;
   } out_reg_t;

   state_e            state_q;
   out_reg_t          out_q,        out_d;
   logic              valid_q,      valid_d;
   logic [LC_W-1:0]   line_cnt_q,   line_cnt_d;
   logic [UW-1:0]     unit_sel_q,   unit_sel_d;
   logic [31:0]       blocks_q,     blocks_d;
   logic              err_q,        err_d;

   logic              in_hs;
   logic              out_hs;
   logic              at_last_line;
   logic              block_done;

   // Only the ready of the unit currently addressed matters.
   assign out_hs       = valid_q & encoder_dispatch_line_rdys[out_q.unit];
   assign dispatch_src_line_rdy = (state_q == RUN) & (~valid_q | out_hs);
   assign in_hs        = src_dispatch_line_val & dispatch_src_line_rdy;
   assign at_last_line = (line_cnt_q == LAST_LINE);
   assign block_done   = in_hs & at_last_line;

   always_comb begin
      out_d      = out_q;
      valid_d    = valid_q;
      line_cnt_d = line_cnt_q;
      unit_sel_d = unit_sel_q;
      blocks_d   = blocks_q;
      err_d      = err_q;

      if (in_hs) begin
         // Load and unload may coincide; the reload wins so streaming has no bubble.
         out_d.data = src_dispatch_line;
         out_d.unit = unit_sel_q;
         valid_d    = 1'b1;
         // Framing is checked but never steers routing; line count alone does.
         if (src_dispatch_line_last != at_last_line) begin
            err_d = 1'b1;
         end
         if (at_last_line) begin
            line_cnt_d = '0;
            unit_sel_d = unit_sel_q + UW'(1);
            blocks_d   = blocks_q + 32'd1;
         end else begin
            line_cnt_d = line_cnt_q + LC_W'(1);
         end
      end else if (out_hs) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         out_q      <= '0;
         valid_q    <= 1'b0;
         line_cnt_q <= '0;
         unit_sel_q <= '0;
         blocks_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (dispatch_en) begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               // Disable only takes effect on a block boundary: either the
               // closing line of a block is accepted now, or nothing of a new
               // block has been accepted yet.
               if (!dispatch_en && (block_done || (line_cnt_q == '0 && !in_hs))) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
         out_q      <= out_d;
         valid_q    <= valid_d;
         line_cnt_q <= line_cnt_d;
         unit_sel_q <= unit_sel_d;
         blocks_q   <= blocks_d;
         err_q      <= err_d;
      end
   end

   assign dispatch_encoder_line_vals =
      valid_q ? ({{(NUM_RS_UNITS-1){1'b0}}, 1'b1} << out_q.unit) : '0;
   assign dispatch_encoder_line = out_q.data;
   assign dispatch_framing_err  = err_q;
   assign dispatch_blocks_sent  = blocks_q;
   assign dispatch_idle         = (state_q == IDLE) & ~valid_q;

endmodule
